// File: rtl/des_key_sched_pkg.sv
// Shared types, constants and helpers for the DES/3DES round-key scheduler (package des_pkg).
package des_pkg;

    localparam logic [15:0] SHIFT_SCHED_DEF = 16'h8103;

    localparam int unsigned PC2_W = 48;

    // PC-2 selection table, 1-based positions into {C,D} counted from the MSB.
    localparam int unsigned PC2_TAB [PC2_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Rotation amount of encrypt round rnd (1..16).
    function automatic logic [1:0] shift_amt(input logic [15:0] sched, input logic [4:0] rnd);
        logic [3:0] idx;
        idx = 4'(rnd - 5'd1);
        return sched[idx] ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// Key-load / schedule-control / round-key stream bundle for des_key_sched.
// RK_W follows DES_KEY_SCHED_PC2_EN: 48 when defined, else 2*HALF_W.
interface des_key_sched_if
    import des_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 3,
    parameter int unsigned HALF_W   = 28
);
    localparam int unsigned SLOT_W = slot_w(NUM_KEYS);
`ifdef DES_KEY_SCHED_PC2_EN
    localparam int unsigned RK_W = PC2_W;
`else
    localparam int unsigned RK_W = 2 * HALF_W;
`endif

    logic                  key_load;
    logic [SLOT_W-1:0]     key_slot;
    logic [2*HALF_W-1:0]   key_in;
    logic                  start;
    mode_e                 mode;
    logic [SLOT_W-1:0]     slot_sel;
    logic                  abort;
    logic                  rk_ready;
    logic                  rk_valid;
    logic [RK_W-1:0]       rk_data;
    logic [4:0]            rk_round;
    logic                  busy;
    logic                  done;

    modport master (
        output key_load, key_slot, key_in, start, mode, slot_sel, abort, rk_ready,
        input  rk_valid, rk_data, rk_round, busy, done
    );

    modport slave (
        input  key_load, key_slot, key_in, start, mode, slot_sel, abort, rk_ready,
        output rk_valid, rk_data, rk_round, busy, done
    );

endinterface

// File: rtl/des_key_sched_cd_rotate.sv
// Combinational rotate of one C or D half by 0, 1 or 2 bits, left or right.
module des_cd_rotate #(
    parameter int unsigned HALF_W = 28
) (
    input  logic [HALF_W-1:0] half_i,
    input  logic [1:0]        amt_i,
    input  logic              left_i,
    output logic [HALF_W-1:0] half_o
);

    always_comb begin
        half_o = half_i;
        case (amt_i)
            2'd1: half_o = left_i ? {half_i[HALF_W-2:0], half_i[HALF_W-1]}
                                  : {half_i[0], half_i[HALF_W-1:1]};
            2'd2: half_o = left_i ? {half_i[HALF_W-3:0], half_i[HALF_W-1:HALF_W-2]}
                                  : {half_i[1:0], half_i[HALF_W-1:2]};
            default: half_o = half_i;
        endcase
    end

endmodule

// File: rtl/des_key_sched.sv
// Handshaked DES/3DES round-key generator holding NUM_KEYS PC-1 keys.
// Define DES_KEY_SCHED_PC2_EN to apply PC-2 internally (needs HALF_W = 28).
module des_key_sched
    import des_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 3,
    parameter int unsigned HALF_W      = 28,
    parameter logic [15:0] SHIFT_SCHED = SHIFT_SCHED_DEF
) (
    input  logic           clk,
    input  logic           rst,
    des_key_sched_if.slave kif
);

    localparam int unsigned     SLOT_W     = slot_w(NUM_KEYS);
    localparam int unsigned     KEY_W      = 2 * HALF_W;
    localparam int unsigned     SLOTS      = 2 ** SLOT_W;
    localparam logic [SLOT_W:0] NUM_KEYS_L = (SLOT_W + 1)'(NUM_KEYS);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [4:0]       rnd_q, rnd_d;
    logic [KEY_W-1:0] cd_q, cd_d;
    logic [KEY_W-1:0] slots_q [SLOTS];

    logic [KEY_W-1:0] rot_src, rot_out;
    logic [1:0]       rot_amt;
    logic             rot_left;
    logic             load_ok, start_ok;

    assign load_ok  = kif.key_load && ({1'b0, kif.key_slot} < NUM_KEYS_L);
    assign start_ok = kif.start && ({1'b0, kif.slot_sel} < NUM_KEYS_L);

    // Slots beyond NUM_KEYS are never written and stay zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                slots_q[SLOT_W'(i)] <= '0;
            end
        end else if (load_ok) begin
            slots_q[kif.key_slot] <= kif.key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= ENC;
            rnd_q   <= '0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
            cd_q    <= cd_d;
        end
    end

    // Rotator setup: slot load on start, otherwise step to the following round.
    always_comb begin
        rot_src  = cd_q;
        rot_left = 1'b1;
        rot_amt  = 2'd0;
        if (state_q == IDLE) begin
            rot_src = slots_q[kif.slot_sel];
            rot_amt = (kif.mode == ENC) ? shift_amt(SHIFT_SCHED, 5'd1) : 2'd0;
        end else if (mode_q == ENC) begin
            rot_amt = shift_amt(SHIFT_SCHED, rnd_q + 5'd1);
        end else begin
            rot_left = 1'b0;
            rot_amt  = shift_amt(SHIFT_SCHED, 5'd17 - rnd_q);
        end
    end

    des_cd_rotate #(.HALF_W(HALF_W)) u_rot_c (
        .half_i (rot_src[KEY_W-1:HALF_W]),
        .amt_i  (rot_amt),
        .left_i (rot_left),
        .half_o (rot_out[KEY_W-1:HALF_W])
    );

    des_cd_rotate #(.HALF_W(HALF_W)) u_rot_d (
        .half_i (rot_src[HALF_W-1:0]),
        .amt_i  (rot_amt),
        .left_i (rot_left),
        .half_o (rot_out[HALF_W-1:0])
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rnd_d   = rnd_q;
        cd_d    = cd_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mode_d  = kif.mode;
                    rnd_d   = 5'd1;
                    cd_d    = rot_out;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (kif.abort) begin
                    state_d = IDLE;
                end else if (kif.rk_ready) begin
                    if (rnd_q == 5'd16) begin
                        state_d = FIN;
                    end else begin
                        rnd_d = rnd_q + 5'd1;
                        cd_d  = rot_out;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign kif.rk_valid = (state_q == RUN);
    assign kif.busy     = (state_q != IDLE);
    assign kif.done     = (state_q == FIN) && !kif.abort;
    assign kif.rk_round = rnd_q;

`ifdef DES_KEY_SCHED_PC2_EN
    for (genvar g = 0; g < PC2_W; g++) begin : g_pc2
        assign kif.rk_data[PC2_W-1-g] = cd_q[KEY_W-PC2_TAB[g]];
    end
`else
    assign kif.rk_data = cd_q;
`endif

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Sequential, parametrised DES/3DES round-key generator. It replaces the purely combinational 16-way key-shift mux with a handshaked engine that holds several PC-1-permuted keys and streams one round key per accepted transfer. Keys stream in encrypt order (left rotations) or decrypt order (right rotations). It sits between the I2C key-register file and the Triple-DES round datapath.

## Interface
- NUM_KEYS, 3, number of 56-bit key slots (K1/K2/K3 for 3DES); must be ≥1
- HALF_W, 28, width of each C/D half
- SHIFT_SCHED, 16'h8103, bit r-1 = 1 means encrypt round r rotates by 1, else by 2 (DES: rounds 1, 2, 9, 16)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_load  in  1  write key_in into slot key_slot
- key_slot  in  $clog2(NUM_KEYS)  write slot index
- key_in  in  2*HALF_W  PC-1 output, {C0,D0}
- start  in  1  begin a 16-round schedule
- mode  in  1  0 = encrypt, 1 = decrypt
- slot_sel  in  $clog2(NUM_KEYS)  slot used by start
- abort  in  1  terminate the current schedule
- rk_ready  in  1  consumer accepts rk_data
- rk_valid  out  1  rk_data/rk_round valid
- rk_data  out  RK_W  round key (RK_W = 48 with PC-2, else 2*HALF_W)
- rk_round  out  5  round number 1..16
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse after round 16 is accepted

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: on start, cd <= first(slot[slot_sel]); rnd <= 1; go to RUN. Encrypt first = rotl(C,1),rotl(D,1). Decrypt first = unrotated {C0,D0}.
- RUN: rk_valid=1. On rk_valid&rk_ready with rnd<16: rnd++ and cd shifts by the next round's amount:
  - encrypt: rotate left by s(rnd+1)
  - decrypt: rotate right by s(18-(rnd+1))
  - s(r) = 1 if SHIFT_SCHED[r-1], else 2
- Handshake on rnd=16 -> FIN.
- FIN: done=1 for one cycle, then IDLE.
- C and D rotate independently, each within HALF_W bits.
- abort in RUN or FIN -> IDLE next cycle, with no done and rk_valid deasserted. Abort wins over a simultaneous handshake.
- start while not IDLE is ignored.
- key_load is accepted in any state. The schedule copies the slot at start, so a running schedule is unaffected.
- start and key_load to the same slot in the same cycle: start uses the old slot contents.
- key_slot or slot_sel ≥ NUM_KEYS: the load is ignored, and start is ignored (stays IDLE).
- rk_data/rk_round hold stable while rk_valid & !rk_ready.

## Timing
- Reset values: rk_valid=0, busy=0, done=0, rk_round=0, rk_data=0, state IDLE, cd=0, all slots 0.
- Start-to-first-key latency is 1 cycle: start sampled at edge N, rk_valid high after edge N.
- With rk_ready tied high: rounds 1..16 on cycles N+1..N+16, done on cycle N+17, start accepted again on N+18.
- busy=1 in RUN and FIN.
- rk_data is combinational from registered cd (PC-2 wiring only). It adds no cycle.
- rst has priority over all inputs.

## Configuration
- DES_KEY_SCHED_PC2_EN defined: rk_data = PC-2(cd), RK_W = 48. Requires HALF_W = 28.
- Undefined: rk_data = raw {C,D}, RK_W = 2*HALF_W. PC-2 is done downstream.

## Structure
- Package des_pkg holds:
  - the default SHIFT_SCHED constant
  - the PC-2 table as a localparam array
  - the mode enum (ENC/DEC)
  - the state enum (IDLE/RUN/FIN)
- Sub-module des_cd_rotate: combinational rotate of one HALF_W half by 0/1/2, left or right. Instantiated twice (C and D).

## Test plan
- Encrypt, PC-2 enabled: load slot 0 = 56'hF0CCAAF_556678F, start mode=0, rk_ready=1 -> round 1 = 48'h1B02EFFC7072, round 16 = 48'hCB3D8B0E17F5, done on cycle N+17.
- Encrypt, PC-2 disabled: same key -> round 1 rk_data = 56'hE19955F_AACCF1E; round 16 = 56'hF0CCAAF_556678F (total rotation 28).
- Decrypt: same key, mode=1 -> round 1 = 48'hCB3D8B0E17F5, round 16 = 48'h1B02EFFC7072. Every round equals encrypt round 17-r.
- Backpressure: toggle rk_ready pseudo-randomly -> exactly 16 handshakes with rk_round 1..16 in order, data stable while stalled, one done pulse.
- Slot and load hazard: load slots 0/1/2 with distinct keys, start slot 2 while loading slot 2 the same cycle -> old key is used. A later start uses the new key.
- Abort/reset: abort at round 5 -> IDLE next cycle, no done. rst at round 9 -> all outputs and slots zero next cycle. start while busy -> ignored.
